// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, request record and default widths.
// Fixed-priority variant is selected with `MEM_ARB_FIXED_PRIORITY_EN (see mem_arb_rr_picker).
package mem_arb_pkg;

   localparam int ARB_NUM_MASTERS = 3;
   localparam int ARB_ADDR_W      = 27;
   localparam int ARB_DATA_W      = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wd;
   } req_t;

   // Round-robin pointer advance: the master after idx, wrapping at n.
   function automatic int next_index(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the single cache-side slave.
// The arbiter sits on the slave modport; the masters plus the cache slave sit on the master modport.
interface data_mem_arbiter_if #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 27,
   parameter int DATA_W      = 32
);

   // Handshake: a master may pulse m_en[i] for one cycle only while m_stall[i] is low; m_stall[i]
   // stays high until that request completes, and m_rd[i] then holds the read data. On the slave
   // side s_en with s_stall low at a clock edge is an accept; the slave raises s_stall the cycle
   // after the accept and s_rd is valid on the first edge where s_stall is low again.
   logic [NUM_MASTERS-1:0]        m_en;
   logic [NUM_MASTERS-1:0]        m_we;
   logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
   logic [NUM_MASTERS*DATA_W-1:0] m_wd;
   logic [NUM_MASTERS-1:0]        m_stall;
   logic [NUM_MASTERS*DATA_W-1:0] m_rd;

   logic              s_en;
   logic              s_we;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wd;
   logic [DATA_W-1:0] s_rd;
   logic              s_stall;

   modport slave (
      input  m_en, m_we, m_addr, m_wd,
      output m_stall, m_rd,
      output s_en, s_we, s_addr, s_wd,
      input  s_rd, s_stall
   );

   modport master (
      output m_en, m_we, m_addr, m_wd,
      input  m_stall, m_rd,
      input  s_en, s_we, s_addr, s_wd,
      output s_rd, s_stall
   );

endinterface

// File: rtl/mem_arb_rr_picker.sv
// Combinational grant picker: first pending master at or after rr_ptr, wrapping around.
// With `MEM_ARB_FIXED_PRIORITY_EN defined the lowest-index pending master wins and rr_ptr is ignored.
module mem_arb_rr_picker #(
   parameter int NUM_MASTERS = 3,
   parameter int PTR_W       = 2
) (
   input  logic [NUM_MASTERS-1:0] pend_v,
   input  logic [PTR_W-1:0]       rr_ptr,
   output logic [NUM_MASTERS-1:0] grant_oh,
   output logic [PTR_W-1:0]       grant_idx
);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
   logic unused_rr;
   assign unused_rr = ^rr_ptr;

   // Scan from the top down so the lowest pending index is the last to overwrite.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (pend_v[i]) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
            grant_idx   = PTR_W'(i);
         end
      end
   end
`else
   logic [PTR_W-1:0] idx;

   // Scan offsets from farthest to nearest so the master closest to rr_ptr wins.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      idx       = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_MASTERS);
         if (pend_v[idx]) begin
            grant_oh      = '0;
            grant_oh[idx] = 1'b1;
            grant_idx     = idx;
         end
      end
   end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// N-master to 1-slave arbiter in front of the DDR2 cache path, one request buffer per master.
// Grant policy is round-robin unless `MEM_ARB_FIXED_PRIORITY_EN is defined.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_MASTERS = ARB_NUM_MASTERS,
   parameter int ADDR_W      = ARB_ADDR_W,
   parameter int DATA_W      = ARB_DATA_W
) (
   input  logic                clock,
   input  logic                reset,
   data_mem_arbiter_if.slave   bus,
   output arb_state_t          dbg_state
);

   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   typedef logic [PTR_W-1:0] ptr_t;

   arb_state_t             state_q, state_d;
   ptr_t                   grant_q, grant_d;
   logic [NUM_MASTERS-1:0] pend_v_q, pend_v_d;
   logic [NUM_MASTERS-1:0] pend_we_q, pend_we_d;
   logic [ADDR_W-1:0]      pend_addr_q [NUM_MASTERS];
   logic [ADDR_W-1:0]      pend_addr_d [NUM_MASTERS];
   logic [DATA_W-1:0]      pend_wd_q   [NUM_MASTERS];
   logic [DATA_W-1:0]      pend_wd_d   [NUM_MASTERS];
   logic [DATA_W-1:0]      m_rd_q      [NUM_MASTERS];
   logic [DATA_W-1:0]      m_rd_d      [NUM_MASTERS];
   logic                   s_we_q, s_we_d;
   logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
   logic [DATA_W-1:0]      s_wd_q, s_wd_d;

   logic [NUM_MASTERS-1:0] pick_oh;
   ptr_t                   pick_idx;
   ptr_t                   pick_ptr;
   logic                   sel_we;
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_wd;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
   assign pick_ptr = '0;
`else
   ptr_t rr_q, rr_d;
   assign pick_ptr = rr_q;
`endif

   mem_arb_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .PTR_W       (PTR_W)
   ) u_picker (
      .pend_v    (pend_v_q),
      .rr_ptr    (pick_ptr),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx)
   );

   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_wd   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_oh[i]) begin
            sel_we   = sel_we | pend_we_q[i];
            sel_addr = sel_addr | pend_addr_q[i];
            sel_wd   = sel_wd | pend_wd_q[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      pend_v_d  = pend_v_q;
      pend_we_d = pend_we_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_wd_d    = s_wd_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      rr_d      = rr_q;
`endif
      for (int i = 0; i < NUM_MASTERS; i++) begin
         pend_addr_d[i] = pend_addr_q[i];
         pend_wd_d[i]   = pend_wd_q[i];
         m_rd_d[i]      = m_rd_q[i];
      end

      // A request on a busy master breaks the contract and is dropped here.
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (bus.m_en[i] && !pend_v_q[i]) begin
            pend_v_d[i]    = 1'b1;
            pend_we_d[i]   = bus.m_we[i];
            pend_addr_d[i] = bus.m_addr[i*ADDR_W +: ADDR_W];
            pend_wd_d[i]   = bus.m_wd[i*DATA_W +: DATA_W];
         end
      end

      case (state_q)
         IDLE: begin
            if (|pend_v_q) begin
               grant_d  = pick_idx;
               s_we_d   = sel_we;
               s_addr_d = sel_addr;
               s_wd_d   = sel_wd;
               state_d  = ISSUE;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
               rr_d     = PTR_W'(next_index(int'(pick_idx), NUM_MASTERS));
`endif
            end
         end
         ISSUE: begin
            if (!bus.s_stall) state_d = WAIT;
         end
         WAIT: begin
            // s_we_q still describes the in-flight request, so writes leave m_rd alone.
            if (!bus.s_stall) begin
               if (!s_we_q) m_rd_d[grant_q] = bus.s_rd;
               pend_v_d[grant_q] = 1'b0;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         pend_v_q  <= '0;
         pend_we_q <= '0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wd_q    <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
         rr_q      <= '0;
`endif
         for (int i = 0; i < NUM_MASTERS; i++) begin
            pend_addr_q[i] <= '0;
            pend_wd_q[i]   <= '0;
            m_rd_q[i]      <= '0;
         end
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         pend_v_q  <= pend_v_d;
         pend_we_q <= pend_we_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wd_q    <= s_wd_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
         rr_q      <= rr_d;
`endif
         for (int i = 0; i < NUM_MASTERS; i++) begin
            pend_addr_q[i] <= pend_addr_d[i];
            pend_wd_q[i]   <= pend_wd_d[i];
            m_rd_q[i]      <= m_rd_d[i];
         end
      end
   end

   always_comb begin
      bus.m_rd = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         bus.m_rd[i*DATA_W +: DATA_W] = m_rd_q[i];
      end
   end

   assign bus.m_stall = pend_v_q;
   assign bus.s_en    = (state_q == ISSUE);
   assign bus.s_we    = s_we_q;
   assign bus.s_addr  = s_addr_q;
   assign bus.s_wd    = s_wd_q;
   assign dbg_state   = state_q;

   master_contract_a: assert property (@(posedge clock) disable iff (reset)
      (bus.m_en & pend_v_q) == '0);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: behavioural cache slave, directed request sequence, report.
// Expected grant orders follow `MEM_ARB_FIXED_PRIORITY_EN when it is defined.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int N  = 3;
   localparam int AW = 27;
   localparam int DW = 32;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   arb_state_t dbg_state;

   data_mem_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   data_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Cache slave model: one stall burst of slv_wait cycles after every accept.
   logic          slv_busy = 1'b0;
   int            slv_cnt = 0;
   int            slv_wait = 1;
   logic          hold_stall = 1'b0;
   logic          slv_we_l = 1'b0;
   logic [AW-1:0] slv_addr_l = '0;
   logic [DW-1:0] slv_rd = '0;
   logic [DW-1:0] mem [int];
   logic [AW-1:0] log_addr [$];
   logic          log_we [$];
   logic [DW-1:0] log_wd [$];
   logic [AW-1:0] exp_q [$];
   int            en_cycles = 0;

   assign bus.s_stall = slv_busy | hold_stall;
   assign bus.s_rd    = slv_rd;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return 32'hA500_0000 ^ DW'(a);
   endfunction

   function automatic logic [DW-1:0] slv_read(input logic [AW-1:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : pat(a);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         slv_busy <= 1'b0;
         slv_cnt  <= 0;
      end else if (slv_busy) begin
         if (slv_cnt == 0) begin
            slv_busy <= 1'b0;
            slv_rd   <= slv_we_l ? 32'h0BAD_0BAD : slv_read(slv_addr_l);
         end else begin
            slv_cnt <= slv_cnt - 1;
         end
      end else if (bus.s_en && !bus.s_stall) begin
         slv_busy   <= 1'b1;
         slv_cnt    <= slv_wait - 1;
         slv_we_l   <= bus.s_we;
         slv_addr_l <= bus.s_addr;
         slv_rd     <= 32'h5A5A_5A5A;
         if (bus.s_we) mem[int'(bus.s_addr)] = bus.s_wd;
         log_addr.push_back(bus.s_addr);
         log_we.push_back(bus.s_we);
         log_wd.push_back(bus.s_wd);
      end
   end

   always @(posedge clock) begin
      if (!reset && bus.s_en) en_cycles <= en_cycles + 1;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_of(input int i);
      return bus.m_rd[i*DW +: DW];
   endfunction

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.m_we[i]          = we;
      bus.m_addr[i*AW +: AW] = a;
      bus.m_wd[i*DW +: DW]   = d;
   endtask

   // Called at a negedge; returns at the negedge after the capturing edge.
   task automatic fire(input logic [N-1:0] mask);
      bus.m_en = mask;
      @(posedge clock);
      @(negedge clock);
      bus.m_en = '0;
   endtask

   task automatic wait_idle(input string tag, input logic [N-1:0] mask, input int budget, output int cycles);
      cycles = 0;
      while (((bus.m_stall & mask) != '0) && cycles < budget) begin
         cycles++;
         @(negedge clock);
      end
      check({tag, "_timeout"}, 64'((bus.m_stall & mask) != '0), 64'd0);
   endtask

   task automatic check_log(input string tag);
      check({tag, "_count"}, 64'(log_addr.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_order%0d", tag, i), (i < log_addr.size()) ? 64'(log_addr[i]) : 64'hx, 64'(exp_q[i]));
      end
      exp_q.delete();
      log_addr.delete();
      log_we.delete();
      log_wd.delete();
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset      = 1'b1;
      bus.m_en   = '0;
      hold_stall = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   int cyc;
   int en0;

   initial begin
      bus.m_en   = '0;
      bus.m_we   = '0;
      bus.m_addr = '0;
      bus.m_wd   = '0;
      mem[32'h10] = 32'hDEAD_BEEF;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Reset state
      check("rst_m_stall", 64'(bus.m_stall), 64'd0);
      check("rst_m_rd", 64'(bus.m_rd), 64'd0);
      check("rst_s_en", 64'(bus.s_en), 64'd0);
      check("rst_s_we", 64'(bus.s_we), 64'd0);
      check("rst_s_addr", 64'(bus.s_addr), 64'd0);
      check("rst_s_wd", 64'(bus.s_wd), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));

      // 1: single read, slave stalls 3 cycles
      slv_wait = 3;
      set_req(0, 1'b0, 27'h10, '0);
      en0 = en_cycles;
      fire(3'b001);
      check("t1_stall_hi", 64'(bus.m_stall[0]), 64'd1);
      wait_idle("t1", 3'b001, 40, cyc);
      check("t1_latency", 64'(cyc), 64'd6);
      check("t1_rd0", 64'(rd_of(0)), 64'hDEAD_BEEF);
      check("t1_rd1", 64'(rd_of(1)), 64'd0);
      check("t1_rd2", 64'(rd_of(2)), 64'd0);
      check("t1_s_en_cycles", 64'(en_cycles - en0), 64'd1);
      exp_q.push_back(27'h10);
      check_log("t1");

      // 2: same-cycle bursts from rr_ptr=0
      do_reset();
      slv_wait = 1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32'h100 + i), '0);
      fire(3'b111);
      wait_idle("t2a", 3'b111, 60, cyc);
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(AW'(32'h100 + i));
         check($sformatf("t2a_rd%0d", i), 64'(rd_of(i)), 64'(pat(AW'(32'h100 + i))));
      end
      check_log("t2a");
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32'h200 + i), '0);
      fire(3'b111);
      wait_idle("t2b", 3'b111, 60, cyc);
      for (int i = 0; i < N; i++) exp_q.push_back(AW'(32'h200 + i));
      check_log("t2b");

      // 3: master 1 back-to-back while master 2 pending
      set_req(1, 1'b0, 27'h301, '0);
      set_req(2, 1'b0, 27'h302, '0);
      fire(3'b110);
      wait_idle("t3a", 3'b010, 40, cyc);
      set_req(1, 1'b0, 27'h311, '0);
      fire(3'b010);
      wait_idle("t3b", 3'b110, 60, cyc);
      exp_q.push_back(27'h301);
      exp_q.push_back(27'h302);
      exp_q.push_back(27'h311);
      check_log("t3");
      check("t3_rd1", 64'(rd_of(1)), 64'(pat(27'h311)));
      check("t3_rd2", 64'(rd_of(2)), 64'(pat(27'h302)));

      // 3b: all three again; round-robin pointer now sits at master 2
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32'h400 + i), '0);
      fire(3'b111);
      wait_idle("t3c", 3'b111, 60, cyc);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      exp_q.push_back(27'h400);
      exp_q.push_back(27'h401);
      exp_q.push_back(27'h402);
`else
      exp_q.push_back(27'h402);
      exp_q.push_back(27'h400);
      exp_q.push_back(27'h401);
`endif
      check_log("t3c");

      // 4: write then read on master 0
      set_req(0, 1'b1, 27'h20, 32'h1234_5678);
      fire(3'b001);
      wait_idle("t4w", 3'b001, 40, cyc);
      check("t4_latency", 64'(cyc), 64'd4);
      check("t4_log_we", (log_we.size() > 0) ? 64'(log_we[0]) : 64'hx, 64'd1);
      check("t4_log_wd", (log_wd.size() > 0) ? 64'(log_wd[0]) : 64'hx, 64'h1234_5678);
      check("t4_rd0_after_wr", 64'(rd_of(0)), 64'(pat(27'h400)));
      check("t4_s_we_held", 64'(bus.s_we), 64'd1);
      exp_q.push_back(27'h20);
      check_log("t4w");
      set_req(0, 1'b0, 27'h20, '0);
      fire(3'b001);
      wait_idle("t4r", 3'b001, 40, cyc);
      check("t4_log_re", (log_we.size() > 0) ? 64'(log_we[0]) : 64'hx, 64'd0);
      check("t4_rd0_after_rd", 64'(rd_of(0)), 64'h1234_5678);
      exp_q.push_back(27'h20);
      check_log("t4r");

      // 5: slave already stalled when ISSUE is entered
      hold_stall = 1'b1;
      set_req(1, 1'b0, 27'h500, '0);
      fire(3'b010);
      repeat (4) @(negedge clock);
      check("t5_s_en_held", 64'(bus.s_en), 64'd1);
      check("t5_s_addr_held", 64'(bus.s_addr), 64'h500);
      check("t5_state", 64'(dbg_state), 64'(ISSUE));
      check("t5_stall1", 64'(bus.m_stall[1]), 64'd1);
      hold_stall = 1'b0;
      wait_idle("t5", 3'b010, 40, cyc);
      check("t5_rd1", 64'(rd_of(1)), 64'(pat(27'h500)));
      exp_q.push_back(27'h500);
      check_log("t5");

      // 6: reset while the arbiter waits on the slave
      do_reset();
      slv_wait = 3;
      set_req(0, 1'b0, 27'h600, '0);
      fire(3'b001);
      @(negedge clock);
      @(negedge clock);
      check("t6_in_wait", 64'(dbg_state), 64'(WAIT));
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("t6_m_stall", 64'(bus.m_stall), 64'd0);
      check("t6_s_en", 64'(bus.s_en), 64'd0);
      check("t6_state", 64'(dbg_state), 64'(IDLE));
      reset = 1'b0;
      slv_wait = 1;
      log_addr.delete();
      log_we.delete();
      log_wd.delete();
      set_req(2, 1'b0, 27'h620, '0);
      fire(3'b100);
      wait_idle("t6", 3'b100, 40, cyc);
      check("t6_rd2", 64'(rd_of(2)), 64'(pat(27'h620)));
      check("t6_rd0_kept", 64'(rd_of(0)), 64'd0);
      exp_q.push_back(27'h620);
      check_log("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
